// File: rtl/rx_pkg.sv
// Shared widths and FSM state encoding for the RX readout controller.
package rx_pkg;

  localparam int RX_CORR_W = 32;
  localparam int RX_PEAK_W = 41;
  localparam int RX_TIME_W = 32;
  localparam int RX_SEQ_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_PUSH     = 3'd3,
    ST_REQ      = 3'd4,
    ST_DONE     = 3'd5
  } rx_state_e;

endpackage

// File: rtl/rx_readout_timer.sv
// Clearable saturating wait counter; expired_o marks the last permitted wait cycle.
module rx_readout_timer #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle in which cnt_q reaches TIMEOUT_CYC-1 is the TIMEOUT_CYC-th wait cycle.
  assign expired_o = en_i && (cnt_q >= CNT_LIM);

endmodule

// File: rtl/rx_readout_ctrl.sv
// Reads NUM_SAMPLES correlator-buffer samples per accepted peak and streams them to the host.
// Optional wait timeout enabled by defining RX_READOUT_TIMEOUT_EN.
module rx_readout_ctrl
  import rx_pkg::*;
#(
  parameter int NUM_SAMPLES = 128,
  parameter int TRIG_HOLD   = 5,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                        crx_clk,
  input  logic                        rrx_rst,
  input  logic                        erx_en,
  input  logic                        ipeak_trigger,
  input  logic signed [RX_PEAK_W-1:0] ipeak_sample,
  input  logic        [RX_TIME_W-1:0] ipeak_time,
  input  logic        [RX_SEQ_W-1:0]  ipeak_seq,
  output logic                        oresult_acquired,
  input  logic signed [RX_CORR_W-1:0] icorr_sample_buff,
  input  logic                        icorr_sample_ready_buff,
  output logic                        onext_sample_trigg_buff,
  output logic                        oall_acquired_buff_trigg,
  output logic signed [RX_PEAK_W-1:0] ohdr_peak,
  output logic        [RX_TIME_W-1:0] ohdr_time,
  output logic        [RX_SEQ_W-1:0]  ohdr_seq,
  output logic                        ohost_valid,
  output logic        [RX_CORR_W-1:0] ohost_data,
  output logic                        ohost_last,
  input  logic                        ihost_ready,
  output logic                        obusy,
  output logic                        odrop,
  output logic                        oerr_timeout
);

  localparam int IDX_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int HOLD_W = (TRIG_HOLD > 1) ? $clog2(TRIG_HOLD) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((TRIG_HOLD > 0) ? TRIG_HOLD - 1 : 0);

  rx_state_e state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic                        low_q, low_d;
  logic signed [RX_PEAK_W-1:0] hdr_peak_q, hdr_peak_d;
  logic [RX_TIME_W-1:0]        hdr_time_q, hdr_time_d;
  logic [RX_SEQ_W-1:0]         hdr_seq_q, hdr_seq_d;
  logic signed [RX_CORR_W-1:0] data_q, data_d;
  logic                        drop_q, drop_d;
  logic                        err_q, err_d;
  logic                        tmo;
  logic                        ack_c, trg_c, all_c, vld_c;

`ifdef RX_READOUT_TIMEOUT_EN
  rx_readout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (crx_clk),
    .rst_ni   (rrx_rst),
    .clr_i    (state_d != state_q),
    .en_i     ((state_q == ST_WAIT_RDY) || (state_q == ST_REQ)),
    .expired_o(tmo)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    low_d      = low_q;
    hdr_peak_d = hdr_peak_q;
    hdr_time_d = hdr_time_q;
    hdr_seq_d  = hdr_seq_q;
    data_d     = data_q;
    err_d      = err_q;
    ack_c      = 1'b0;
    trg_c      = 1'b0;
    all_c      = 1'b0;
    vld_c      = 1'b0;
    drop_d     = ipeak_trigger && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (ipeak_trigger && erx_en) begin
          state_d    = ST_ACK;
          hdr_peak_d = ipeak_sample;
          hdr_time_d = ipeak_time;
          hdr_seq_d  = ipeak_seq;
        end
      end
      ST_ACK: begin
        ack_c   = 1'b1;
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (icorr_sample_ready_buff) begin
          data_d  = icorr_sample_buff;
          state_d = ST_PUSH;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_PUSH: begin
        vld_c = 1'b1;
        if (ihost_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            hold_d  = '0;
            low_d   = 1'b0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        trg_c = 1'b1;
        if (hold_q != HOLD_LIM) hold_d = hold_q + HOLD_W'(1);
        if (!icorr_sample_ready_buff) low_d = 1'b1;
        // Ready must have been seen low so the stale sample is never recaptured.
        if ((hold_q >= HOLD_LIM) && (low_q || !icorr_sample_ready_buff)) begin
          state_d = ST_WAIT_RDY;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        all_c   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable aborts any readout silently; the header stays latched.
    if (!erx_en) begin
      state_d = ST_IDLE;
      ack_c   = 1'b0;
      trg_c   = 1'b0;
      all_c   = 1'b0;
      vld_c   = 1'b0;
    end
  end

  always_ff @(posedge crx_clk) begin
    if (!rrx_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      low_q      <= 1'b0;
      hdr_peak_q <= '0;
      hdr_time_q <= '0;
      hdr_seq_q  <= '0;
      data_q     <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      low_q      <= low_d;
      hdr_peak_q <= hdr_peak_d;
      hdr_time_q <= hdr_time_d;
      hdr_seq_q  <= hdr_seq_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign oresult_acquired         = ack_c;
  assign onext_sample_trigg_buff  = trg_c;
  assign oall_acquired_buff_trigg = all_c;
  assign ohost_valid              = vld_c;
  assign ohost_last               = vld_c && (idx_q == IDX_LAST);
  assign ohost_data               = data_q;
  assign ohdr_peak                = hdr_peak_q;
  assign ohdr_time                = hdr_time_q;
  assign ohdr_seq                 = hdr_seq_q;
  assign obusy                    = (state_q != ST_IDLE);
  assign odrop                    = drop_q;
  assign oerr_timeout             = err_q;

endmodule

// File: tb/tb_rx_readout_ctrl.sv
// Directed bench for rx_readout_ctrl: buffer and host models with per-beat data checks.
module tb_rx_readout_ctrl;
  import rx_pkg::*;

  localparam int N = 128;

  logic                        crx_clk = 1'b0;
  logic                        rrx_rst, erx_en, ipeak_trigger;
  logic signed [RX_PEAK_W-1:0] ipeak_sample;
  logic        [RX_TIME_W-1:0] ipeak_time;
  logic        [RX_SEQ_W-1:0]  ipeak_seq;
  logic                        oresult_acquired;
  logic signed [RX_CORR_W-1:0] icorr_sample_buff;
  logic                        icorr_sample_ready_buff;
  logic                        onext_sample_trigg_buff, oall_acquired_buff_trigg;
  logic signed [RX_PEAK_W-1:0] ohdr_peak;
  logic        [RX_TIME_W-1:0] ohdr_time;
  logic        [RX_SEQ_W-1:0]  ohdr_seq;
  logic                        ohost_valid, ohost_last, ihost_ready;
  logic        [RX_CORR_W-1:0] ohost_data;
  logic                        obusy, odrop, oerr_timeout;

  int checks = 0, failures = 0;
  int beats = 0, ack_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int hold_high = 0, stall_beat = -1, stall_left = 0;
  bit buf_en = 1'b1;
  int buf_idx = 0, req_cnt = 0;
  logic signed [RX_PEAK_W-1:0] exp_peak;

  always #5 crx_clk = ~crx_clk;

  rx_readout_ctrl dut (
    .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
    .ipeak_trigger(ipeak_trigger), .ipeak_sample(ipeak_sample),
    .ipeak_time(ipeak_time), .ipeak_seq(ipeak_seq),
    .oresult_acquired(oresult_acquired),
    .icorr_sample_buff(icorr_sample_buff),
    .icorr_sample_ready_buff(icorr_sample_ready_buff),
    .onext_sample_trigg_buff(onext_sample_trigg_buff),
    .oall_acquired_buff_trigg(oall_acquired_buff_trigg),
    .ohdr_peak(ohdr_peak), .ohdr_time(ohdr_time), .ohdr_seq(ohdr_seq),
    .ohost_valid(ohost_valid), .ohost_data(ohost_data),
    .ohost_last(ohost_last), .ihost_ready(ihost_ready),
    .obusy(obusy), .odrop(odrop), .oerr_timeout(oerr_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sval(input int k);
    return 32'(k * 1000 - 50000);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge crx_clk);
  endtask

  task automatic clear_counts();
    beats = 0; ack_cnt = 0; done_cnt = 0; drop_cnt = 0;
  endtask

  task automatic start_readout(input int peak, input int tm, input int seq);
    ipeak_trigger = 1'b1;
    ipeak_sample  = RX_PEAK_W'(peak);
    ipeak_time    = RX_TIME_W'(tm);
    ipeak_seq     = RX_SEQ_W'(seq);
    @(negedge crx_clk);
    ipeak_trigger = 1'b0;
    chk("ack_latency", 64'(oresult_acquired), 64'(1));
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (done_cnt < n && c < 20000) begin
      @(negedge crx_clk);
      c++;
    end
    chk("done_seen", 64'(done_cnt), 64'(n));
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (beats < n && c < 5000) begin
      @(negedge crx_clk);
      c++;
    end
    chk("reach_beat", 64'(beats >= n), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(obusy), 64'(0));
    chk({tag, "_valid"}, 64'(ohost_valid), 64'(0));
    chk({tag, "_data"},  64'(ohost_data), 64'(0));
    chk({tag, "_last"},  64'(ohost_last), 64'(0));
    chk({tag, "_peak"},  64'(ohdr_peak), 64'(0));
    chk({tag, "_time"},  64'(ohdr_time), 64'(0));
    chk({tag, "_seq"},   64'(ohdr_seq), 64'(0));
    chk({tag, "_strb"},  64'({oresult_acquired, onext_sample_trigg_buff,
                              oall_acquired_buff_trigg, odrop, oerr_timeout}), 64'(0));
  endtask

  // Buffer model: drops ready for one cycle after hold_high request cycles, then offers the next sample.
  initial begin
    icorr_sample_ready_buff = 1'b0;
    icorr_sample_buff       = '0;
    forever begin
      @(negedge crx_clk);
      if (oresult_acquired) begin
        buf_idx = 0;
        icorr_sample_buff = sval(0);
        icorr_sample_ready_buff = buf_en;
        req_cnt = 0;
      end else if (onext_sample_trigg_buff) begin
        req_cnt++;
        if (req_cnt == hold_high + 1) begin
          icorr_sample_ready_buff = 1'b0;
          buf_idx++;
          icorr_sample_buff = sval(buf_idx);
        end else if (req_cnt > hold_high + 1) begin
          icorr_sample_ready_buff = buf_en;
        end
      end else begin
        req_cnt = 0;
        icorr_sample_ready_buff = buf_en;
      end
    end
  end

  // Host sink and strobe counters.
  initial begin
    ihost_ready = 1'b1;
    forever begin
      @(negedge crx_clk);
      if (oresult_acquired) ack_cnt++;
      if (oall_acquired_buff_trigg) done_cnt++;
      if (odrop) drop_cnt++;
      if (ohost_valid) begin
        if (beats == stall_beat) begin
          stall_left = 10;
          stall_beat = -1;
        end
        if (stall_left > 0) begin
          ihost_ready = 1'b0;
          stall_left--;
          chk("stall_data", 64'(ohost_data), 64'(sval(beats)));
          chk("stall_no_req", 64'(onext_sample_trigg_buff), 64'(0));
        end else begin
          ihost_ready = 1'b1;
          chk("beat_data", 64'(ohost_data), 64'(sval(beats)));
          chk("beat_last", 64'(ohost_last), 64'(beats == N - 1));
          beats++;
        end
      end else begin
        ihost_ready = 1'b1;
      end
    end
  end

  initial begin
    rrx_rst = 1'b0; erx_en = 1'b1; ipeak_trigger = 1'b0;
    ipeak_sample = '0; ipeak_time = '0; ipeak_seq = '0;
    tick(3);
    chk_all_zero("reset");
    rrx_rst = 1'b1;
    tick(2);

    // Basic readout with header latch
    clear_counts();
    exp_peak = -41'sd5000;
    start_readout(-5000, 1234, 13);
    chk("hdr_peak", 64'(ohdr_peak), 64'(exp_peak));
    chk("hdr_time", 64'(ohdr_time), 64'(1234));
    chk("hdr_seq", 64'(ohdr_seq), 64'(13));
    chk("busy_ack", 64'(obusy), 64'(1));
    tick(1);
    chk("ack_one_cycle", 64'(oresult_acquired), 64'(0));
    wait_done(1);
    tick(3);
    chk("t1_beats", 64'(beats), 64'(N));
    chk("t1_acks", 64'(ack_cnt), 64'(1));
    chk("t1_done_once", 64'(done_cnt), 64'(1));
    chk("t1_idle", 64'(obusy), 64'(0));
    chk("t1_hdr_held", 64'(ohdr_peak), 64'(exp_peak));

    // Ready held high through the first REQ cycles
    hold_high = 5;
    clear_counts();
    start_readout(100, 2, 1);
    wait_done(1);
    tick(2);
    chk("t2_beats", 64'(beats), 64'(N));
    hold_high = 0;

    // Host stall on beat 3
    stall_beat = 3;
    clear_counts();
    start_readout(200, 3, 2);
    wait_done(1);
    tick(2);
    chk("t3_beats", 64'(beats), 64'(N));
    chk("t3_stalled", 64'(stall_beat), 64'(-1));

    // Second trigger mid-readout is dropped
    clear_counts();
    start_readout(300, 4, 5);
    wait_beats(40);
    ipeak_trigger = 1'b1; ipeak_seq = 4'd7;
    @(negedge crx_clk);
    ipeak_trigger = 1'b0;
    chk("drop_pulse", 64'(odrop), 64'(1));
    chk("drop_no_ack", 64'(oresult_acquired), 64'(0));
    tick(1);
    chk("drop_one_cycle", 64'(odrop), 64'(0));
    wait_done(1);
    tick(2);
    chk("t4_beats", 64'(beats), 64'(N));
    chk("t4_acks", 64'(ack_cnt), 64'(1));
    chk("t4_drops", 64'(drop_cnt), 64'(1));
    chk("t4_hdr_seq", 64'(ohdr_seq), 64'(5));

    // Reset mid-readout, then restart from index 0
    clear_counts();
    start_readout(400, 5, 6);
    wait_beats(60);
    rrx_rst = 1'b0;
    @(negedge crx_clk);
    rrx_rst = 1'b1;
    chk_all_zero("midrst");
    tick(5);
    chk("midrst_no_done", 64'(done_cnt), 64'(0));
    clear_counts();
    start_readout(500, 6, 8);
    wait_done(1);
    tick(2);
    chk("t5_beats", 64'(beats), 64'(N));

    // Disable mid-readout aborts without a DONE strobe
    clear_counts();
    start_readout(600, 7, 9);
    wait_beats(10);
    erx_en = 1'b0;
    @(negedge crx_clk);
    chk("dis_idle", 64'(obusy), 64'(0));
    chk("dis_valid", 64'(ohost_valid), 64'(0));
    erx_en = 1'b1;
    tick(5);
    chk("dis_no_done", 64'(done_cnt), 64'(0));
    chk("dis_hdr_held", 64'(ohdr_seq), 64'(9));

`ifdef RX_READOUT_TIMEOUT_EN
    begin
      int c = 0;
      buf_en = 1'b0;
      clear_counts();
      start_readout(700, 8, 10);
      while (!oall_acquired_buff_trigg && c < 2000) begin
        @(negedge crx_clk);
        c++;
      end
      chk("tmo_cycles", 64'(c), 64'(1024));
      chk("tmo_err", 64'(oerr_timeout), 64'(1));
      chk("tmo_beats", 64'(beats), 64'(0));
      buf_en = 1'b1;
      tick(3);
      chk("tmo_sticky", 64'(oerr_timeout), 64'(1));
      clear_counts();
      start_readout(800, 9, 11);
      tick(1);
      chk("tmo_cleared", 64'(oerr_timeout), 64'(0));
      wait_done(1);
      tick(2);
      chk("tmo_next_beats", 64'(beats), 64'(N));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
